fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus F/D pipeline register, directly upstream of the opcode decoder.
- Owns the PC and drives the instruction-memory address.
- Registers the fetched word, its PC and PC+1 into the F/D latch for decode.
- Handles decode stalls and back-end redirects (branch, jr, bex), and pre-decodes j/jal so they redirect the PC with zero bubbles.

Parameters:
PC_W, 12, width of PC and instruction-memory word address
RESET_PC, 0, PC value loaded on reset

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hold PC and F/D latch this cycle (from hazard logic)
redirect  input  1  taken branch/jump resolved downstream; flush F/D and load redirect_pc
redirect_pc  input  PC_W  target PC for redirect
q_imem  input  32  instruction word at address_imem, combinational same-cycle response
address_imem  output  PC_W  current PC, driven combinationally from PC register
fd_insn  output  32  latched instruction for decode (opcode = fd_insn[31:27])
fd_pc  output  PC_W  PC of fd_insn
fd_pc_plus1  output  PC_W  fd_pc+1 mod 2^PC_W (jal link value, branch base)
fd_valid  output  1  fd_insn holds a real fetched instruction

Behaviour:
- State: PC register plus F/D latch (fd_insn, fd_pc, fd_pc_plus1, fd_valid).
- address_imem = PC at all times, with no registering.

Reset:
- PC=RESET_PC; fd_insn=0, fd_pc=0, fd_pc_plus1=0, fd_valid=0.
- The first real fetch latches on the first non-reset edge.
- fd_insn=0 decodes as an r_type add $0,$0,$0, i.e. a harmless nop.

Per rising edge, priority reset > redirect > stall > advance:
- redirect=1:
  - PC<=redirect_pc.
  - fd_insn<=0, fd_valid<=0 (flush); fd_pc and fd_pc_plus1 <=0.
  - stall is ignored that cycle.
- stall=1 (no redirect): PC and the whole F/D latch hold.
- Advance:
  - fd_insn<=q_imem, fd_pc<=PC, fd_pc_plus1<=PC+1, fd_valid<=1.
  - PC<=next_pc.

Early jump pre-decode (combinational on q_imem):
- Applies when q_imem[31:27]==5'b00001 (j) or 5'b00011 (jal).
- next_pc = q_imem[PC_W-1:0], i.e. the target field truncated to PC_W.
- The j/jal itself is still latched into F/D (jal needs fd_pc_plus1 for $31).
- Otherwise next_pc = PC+1.
- jr (00100), bex (10110), bne (00010) and blt (00110) are NOT pre-decoded; they rely on redirect.

Arithmetic:
- All PC arithmetic is mod 2^PC_W.
- PC = all-ones advances to 0; fd_pc_plus1 wraps the same way.

Latency:
- A word appears on fd_insn one edge after its address is presented.
- After a redirect: one flushed cycle (fd_valid=0), then the target instruction is latched on the next advancing edge.

Boundary cases:
- redirect and stall together: redirect wins.
- Early-jump word fetched while stall=1: no effect until the stall clears.
- Early jump in the same cycle as redirect: redirect wins.
- reset asserted mid-stall or mid-redirect: reset wins and all state clears.

Optional Feature:
FETCH_PERF_EN
- Defined:
  - Adds outputs perf_fetched[31:0] and perf_flushed[31:0].
  - perf_fetched increments on every advancing edge.
  - perf_flushed increments on every redirect edge.
  - Both reset to 0 and saturate at 32'hFFFFFFFF.
- Undefined: neither port nor counter exists; the port list is exactly as above.

Test Plan:
- Reset, then 4 edges of nop words, no stall, RESET_PC=0:
  - address_imem steps 0,1,2,3,4.
  - fd_pc=0,1,2,3; fd_pc_plus1=1,2,3,4; fd_valid=1 from the first post-reset edge.
- At PC=5 present q_imem=32'h08000040 (j 0x40), no stall:
  - fd_insn=32'h08000040, fd_pc=5.
  - Next address_imem=0x040; no fd_valid=0 gap.
- Stall held 3 cycles at PC=7:
  - address_imem stays 7; fd_insn/fd_pc/fd_valid unchanged.
  - Release: fd_pc=7, then address_imem=8.
- redirect=1, redirect_pc=0x123 with stall=1 at the same edge:
  - Next address_imem=0x123, fd_valid=0, fd_insn=0.
  - Following edge: fd_pc=0x123.
- PC=0xFFF, nop word, PC_W=12: fd_pc=0xFFF, fd_pc_plus1=0x000, next address_imem=0x000.
- Assert reset during a stalled cycle with fd_valid=1: next edge PC=RESET_PC, all fd_* = 0; perf counters = 0 when FETCH_PERF_EN is defined.

Source files
------------

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: control, imem and F/D latch signals between fetch and its neighbours
interface fetch_stage_if #(parameter int PC_W = 12);
  logic stall;
  logic redirect;
  logic [PC_W-1:0] redirect_pc;
  logic [31:0] q_imem;
  logic [PC_W-1:0] address_imem;
  logic [31:0] fd_insn;
  logic [PC_W-1:0] fd_pc;
  logic [PC_W-1:0] fd_pc_plus1;
  logic fd_valid;
  modport master (
    input stall, redirect, redirect_pc, q_imem,
    output address_imem, fd_insn, fd_pc, fd_pc_plus1, fd_valid
  );
  modport slave (
    output stall, redirect, redirect_pc, q_imem,
    input address_imem, fd_insn, fd_pc, fd_pc_plus1, fd_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and F/D latch with zero-bubble j/jal pre-decode; FETCH_PERF_EN adds perf counters
module fetch_stage #(
  parameter int PC_W = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic clock,
  input logic reset,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus1;
  logic [PC_W-1:0] next_pc;
  logic early_jump;
  always_comb begin
    pc_plus1 = pc + PC_W'(1);
    early_jump = bus.q_imem[31:27] == 5'b00001 || bus.q_imem[31:27] == 5'b00011;
    next_pc = early_jump ? bus.q_imem[PC_W-1:0] : pc_plus1;
  end
  assign bus.address_imem = pc;
  always_ff @(posedge clock) begin
    if (reset || bus.redirect) begin
      pc <= reset ? RESET_PC : bus.redirect_pc;
      bus.fd_insn <= '0;
      bus.fd_pc <= '0;
      bus.fd_pc_plus1 <= '0;
      bus.fd_valid <= 1'b0;
    end else if (!bus.stall) begin
      pc <= next_pc;
      bus.fd_insn <= bus.q_imem;
      bus.fd_pc <= pc;
      bus.fd_pc_plus1 <= pc_plus1;
      bus.fd_valid <= 1'b1;
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (!bus.redirect && !bus.stall && !(&perf_fetched)) perf_fetched <= perf_fetched + 32'd1;
      if (bus.redirect && !(&perf_flushed)) perf_flushed <= perf_flushed + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors with a scoreboard queue checked by an independent monitor
module tb_fetch_stage;
  logic clock = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  fetch_stage_if #(.PC_W(12)) bus ();
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif
  fetch_stage #(.PC_W(12), .RESET_PC(12'h000)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushed(perf_flushed)
`endif
  );
  typedef struct {
    logic rst, stall, redir;
    logic [11:0] rpc;
    logic [31:0] q;
    logic [11:0] addr;
    logic [31:0] insn;
    logic [11:0] pc, pc1;
    logic valid;
  } vec_t;
  typedef struct {
    logic [11:0] addr;
    logic [31:0] insn;
    logic [11:0] pc, pc1;
    logic valid;
    logic [31:0] fetched, flushed;
  } exp_t;
  vec_t vecs[$];
  exp_t sb[$];
  task automatic add(input logic rst, stall, redir, input logic [11:0] rpc, input logic [31:0] q,
                     input logic [11:0] addr, input logic [31:0] insn, input logic [11:0] pc, pc1,
                     input logic valid);
    vec_t v;
    v.rst = rst; v.stall = stall; v.redir = redir; v.rpc = rpc; v.q = q;
    v.addr = addr; v.insn = insn; v.pc = pc; v.pc1 = pc1; v.valid = valid;
    vecs.push_back(v);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("address_imem", 32'(bus.address_imem), 32'(e.addr));
        chk("fd_insn", bus.fd_insn, e.insn);
        chk("fd_pc", 32'(bus.fd_pc), 32'(e.pc));
        chk("fd_pc_plus1", 32'(bus.fd_pc_plus1), 32'(e.pc1));
        chk("fd_valid", 32'(bus.fd_valid), 32'(e.valid));
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, e.fetched);
        chk("perf_flushed", perf_flushed, e.flushed);
`endif
      end
    end
  end
  initial begin
    logic [31:0] n_fetch = 0, n_flush = 0;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.q_imem = '0;
    //   rst stall redir rpc      q             addr     insn          pc       pc1      valid
    add(1, 0, 0, 12'h000, 32'h0000_0000, 12'h000, 32'h0000_0000, 12'h000, 12'h000, 0);
    add(1, 0, 0, 12'h000, 32'h0000_0000, 12'h000, 32'h0000_0000, 12'h000, 12'h000, 0);
    add(0, 0, 0, 12'h000, 32'h0000_0000, 12'h001, 32'h0000_0000, 12'h000, 12'h001, 1);
    add(0, 0, 0, 12'h000, 32'h0000_0000, 12'h002, 32'h0000_0000, 12'h001, 12'h002, 1);
    add(0, 0, 0, 12'h000, 32'h0000_0000, 12'h003, 32'h0000_0000, 12'h002, 12'h003, 1);
    add(0, 0, 0, 12'h000, 32'h0000_0000, 12'h004, 32'h0000_0000, 12'h003, 12'h004, 1);
    add(0, 0, 0, 12'h000, 32'h2000_0000, 12'h005, 32'h2000_0000, 12'h004, 12'h005, 1);
    add(0, 0, 0, 12'h000, 32'h0800_0040, 12'h040, 32'h0800_0040, 12'h005, 12'h006, 1);
    add(0, 0, 0, 12'h000, 32'h0C00_0007, 12'h007, 32'h0C00_0007, 12'h040, 12'h041, 1);
    add(0, 1, 0, 12'h000, 32'h1111_1111, 12'h007, 32'h0C00_0007, 12'h040, 12'h041, 1);
    add(0, 1, 0, 12'h000, 32'h0800_0100, 12'h007, 32'h0C00_0007, 12'h040, 12'h041, 1);
    add(0, 1, 0, 12'h000, 32'h0000_0000, 12'h007, 32'h0C00_0007, 12'h040, 12'h041, 1);
    add(0, 0, 0, 12'h000, 32'h2222_2222, 12'h008, 32'h2222_2222, 12'h007, 12'h008, 1);
    add(0, 1, 1, 12'h123, 32'h0800_0040, 12'h123, 32'h0000_0000, 12'h000, 12'h000, 0);
    add(0, 0, 0, 12'h000, 32'h3333_3333, 12'h124, 32'h3333_3333, 12'h123, 12'h124, 1);
    add(0, 0, 1, 12'hFFF, 32'h0000_0000, 12'hFFF, 32'h0000_0000, 12'h000, 12'h000, 0);
    add(0, 0, 0, 12'h000, 32'h0000_0000, 12'h000, 32'h0000_0000, 12'hFFF, 12'h000, 1);
    add(0, 0, 0, 12'h000, 32'h0FFF_F5A5, 12'h5A5, 32'h0FFF_F5A5, 12'h000, 12'h001, 1);
    add(0, 1, 0, 12'h000, 32'h0000_0000, 12'h5A5, 32'h0FFF_F5A5, 12'h000, 12'h001, 1);
    add(1, 1, 1, 12'h777, 32'h0000_0000, 12'h000, 32'h0000_0000, 12'h000, 12'h000, 0);
    add(0, 0, 0, 12'h000, 32'h0000_0000, 12'h001, 32'h0000_0000, 12'h000, 12'h001, 1);
    foreach (vecs[i]) begin
      exp_t e;
      @(negedge clock);
      reset = vecs[i].rst;
      bus.stall = vecs[i].stall;
      bus.redirect = vecs[i].redir;
      bus.redirect_pc = vecs[i].rpc;
      bus.q_imem = vecs[i].q;
      if (vecs[i].rst) begin
        n_fetch = 0;
        n_flush = 0;
      end else if (vecs[i].redir) n_flush++;
      else if (!vecs[i].stall) n_fetch++;
      e.addr = vecs[i].addr; e.insn = vecs[i].insn; e.pc = vecs[i].pc;
      e.pc1 = vecs[i].pc1; e.valid = vecs[i].valid;
      e.fetched = n_fetch; e.flushed = n_flush;
      sb.push_back(e);
    end
    @(negedge clock);
    bus.stall = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
